// File: rtl/serial_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : serial_pkg                                                |
// | Purpose  : Shared constants and state encoding for the serial link   |
// |            (transmitter and receiver sides).                         |
// | Contents : COMMA_BC, BYTE_W, CNT_W, state_t, bc_sat_inc()            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package serial_pkg;

   localparam logic [7:0] COMMA_BC = 8'hBC;
   localparam int         BYTE_W   = 8;
   localparam int         CNT_W    = 3;

   // Encoding is shared with the receiver, so the values are pinned.
   typedef enum logic [1:0] {
      RST = 2'd0,
      PRE = 2'd1,
      ACT = 2'd2
   } state_t;

   // 4-bit saturating increment used by the comma counters.
   function automatic logic [3:0] bc_sat_inc(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

endpackage : serial_pkg
`default_nettype wire

// File: rtl/serial_paralelo_tx_piso.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : serial_piso_shift                                         |
// | Purpose  : 8-bit load/shift register with 3-bit bit counter and a    |
// |            byte-boundary strobe (cnt == 7).                          |
// | Ports    : clk, reset   - clock / sync active-high reset             |
// |            en           - shift and count when not loading           |
// |            load         - load load_byte, restart bit counter        |
// |            load_byte    - next byte to serialise                     |
// |            msb          - current serial bit (registered sh[7])      |
// |            cnt          - bit counter                                |
// |            boundary     - last bit of the current byte               |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module serial_piso_shift
   import serial_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              load,
   input  logic [BYTE_W-1:0] load_byte,
   output logic              msb,
   output logic [CNT_W-1:0]  cnt,
   output logic              boundary
);

   logic [BYTE_W-1:0] sh_q, sh_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   // A load always restarts the counter; at a boundary this coincides
   // with the natural 7 -> 0 wrap, and on leaving RST it starts at 0.
   always_comb begin
      sh_d  = sh_q;
      cnt_d = cnt_q;
      if (load) begin
         sh_d  = load_byte;
         cnt_d = '0;
      end else if (en) begin
         sh_d  = {sh_q[BYTE_W-2:0], 1'b0};
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sh_q  <= '0;
         cnt_q <= '0;
      end else begin
         sh_q  <= sh_d;
         cnt_q <= cnt_d;
      end
   end

   assign msb      = sh_q[BYTE_W-1];
   assign cnt      = cnt_q;
   assign boundary = (cnt_q == 3'd7);

endmodule : serial_piso_shift
`default_nettype wire

// File: rtl/serial_paralelo_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : serial_paralelo_tx                                        |
// | Purpose  : Parallel-to-serial transmitter. After reset sends         |
// |            BC_PREAMBLE comma bytes, then streams accepted bytes MSB  |
// |            first, filling empty byte slots with COMMA.               |
// | Ports    : clk_32f   - serial bit clock                              |
// |            reset     - synchronous active-high reset                 |
// |            data_in   - parallel byte, valid_in qualifies it          |
// |            ready_out - byte accepted when valid_in && ready_out      |
// |            data_out  - serial stream, MSB first                      |
// |            active    - preamble complete                             |
// |            idle_out  - byte on the wire is idle fill                 |
// |            BC_counter- commas loaded since reset, saturating at 15   |
// |                        (only with SER_TX_BC_COUNT_EN defined)        |
// | Options  : `define SER_TX_BC_COUNT_EN adds the BC_counter output.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module serial_paralelo_tx
   import serial_pkg::*;
#(
   parameter int          BC_PREAMBLE = 4,
   parameter logic [7:0]  COMMA       = COMMA_BC
) (
   input  logic              clk_32f,
   input  logic              reset,
   input  logic [BYTE_W-1:0] data_in,
   input  logic              valid_in,
   output logic              ready_out,
   output logic              data_out,
   output logic              active,
`ifdef SER_TX_BC_COUNT_EN
   output logic [3:0]        BC_counter,
`endif
   output logic              idle_out
);

   localparam logic [3:0] c_preamble = 4'(BC_PREAMBLE);

   state_t            state_q, state_d;
   logic [3:0]        pre_cnt_q, pre_cnt_d;
   logic [BYTE_W-1:0] buf_q, buf_d;
   logic              buf_full_q, buf_full_d;
   logic              active_q, active_d;
   logic              idle_q, idle_d;

   logic              load;
   logic [BYTE_W-1:0] load_byte;
   logic [CNT_W-1:0]  cnt;
   logic              boundary;

   serial_piso_shift u_piso (
      .clk       (clk_32f),
      .reset     (reset),
      .en        (state_q != RST),
      .load      (load),
      .load_byte (load_byte),
      .msb       (data_out),
      .cnt       (cnt),
      .boundary  (boundary)
   );

   // At the boundary the buffer drains into the shifter, so a new byte
   // can be taken on that same edge even though the buffer is full.
   assign ready_out = active_q && (!buf_full_q || (cnt == 3'd7));

   always_comb begin
      state_d    = state_q;
      pre_cnt_d  = pre_cnt_q;
      buf_d      = buf_q;
      buf_full_d = buf_full_q;
      active_d   = active_q;
      idle_d     = idle_q;
      load       = 1'b0;
      load_byte  = COMMA;
      case (state_q)
         RST: begin
            load      = 1'b1;
            state_d   = PRE;
            pre_cnt_d = 4'd1;
            idle_d    = 1'b1;
         end
         PRE: begin
            if (boundary) begin
               load = 1'b1;
               if (pre_cnt_q == c_preamble) begin
                  state_d  = ACT;
                  active_d = 1'b1;
               end else begin
                  pre_cnt_d = pre_cnt_q + 4'd1;
               end
            end
         end
         ACT: begin
            if (boundary) begin
               load = 1'b1;
               if (buf_full_q) begin
                  load_byte  = buf_q;
                  buf_full_d = 1'b0;
                  idle_d     = 1'b0;
               end else begin
                  idle_d = 1'b1;
               end
            end
            // Evaluated after the drain so accept-and-drain keeps it full.
            if (valid_in && ready_out) begin
               buf_d      = data_in;
               buf_full_d = 1'b1;
            end
         end
         default: state_d = RST;
      endcase
   end

   always_ff @(posedge clk_32f) begin
      if (reset) begin
         state_q    <= RST;
         pre_cnt_q  <= 4'd0;
         buf_q      <= '0;
         buf_full_q <= 1'b0;
         active_q   <= 1'b0;
         idle_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         pre_cnt_q  <= pre_cnt_d;
         buf_q      <= buf_d;
         buf_full_q <= buf_full_d;
         active_q   <= active_d;
         idle_q     <= idle_d;
      end
   end

   assign active   = active_q;
   assign idle_out = idle_q;

`ifdef SER_TX_BC_COUNT_EN
   // Every load that is comma fill (preamble or idle) sets idle_d, while
   // data loads clear it, so data bytes equal to COMMA are not counted.
   logic [3:0] bc_cnt_q;
   logic       bc_inc;

   assign bc_inc = load && idle_d;

   always_ff @(posedge clk_32f) begin
      if (reset) begin
         bc_cnt_q <= 4'd0;
      end else if (bc_inc) begin
         bc_cnt_q <= bc_sat_inc(bc_cnt_q);
      end
   end

   assign BC_counter = bc_cnt_q;
`endif

endmodule : serial_paralelo_tx
`default_nettype wire

// File: tb/tb_serial_paralelo_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_serial_paralelo_tx                                     |
// | Purpose  : Directed self-checking bench for serial_paralelo_tx with  |
// |            BC_PREAMBLE = 4. Checks BC_counter when                   |
// |            SER_TX_BC_COUNT_EN is defined.                            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_serial_paralelo_tx;

   logic       clk_32f = 1'b0;
   logic       reset;
   logic [7:0] data_in;
   logic       valid_in;
   logic       ready_out;
   logic       data_out;
   logic       active;
   logic       idle_out;
`ifdef SER_TX_BC_COUNT_EN
   logic [3:0] BC_counter;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] txq[$];

   serial_paralelo_tx #(
      .BC_PREAMBLE (4),
      .COMMA       (8'hBC)
   ) dut (
      .clk_32f   (clk_32f),
      .reset     (reset),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .ready_out (ready_out),
      .data_out  (data_out),
      .active    (active),
`ifdef SER_TX_BC_COUNT_EN
      .BC_counter(BC_counter),
`endif
      .idle_out  (idle_out)
   );

   always #5 clk_32f = ~clk_32f;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   // One clock; the producer advances its queue when the edge accepted.
   // ready_out depends only on registers, so sampling it before the edge
   // gives exactly the accept condition seen by the DUT.
   task automatic tick();
      logic acc;
      acc = valid_in && ready_out;
      @(posedge clk_32f);
      #1;
      if (acc) begin
         if (txq.size() > 0) data_in = txq.pop_front();
         else                valid_in = 1'b0;
      end
   endtask

   // Collects one byte slot starting at its load edge. Returns the byte,
   // idle_out/active just after the load and ready_out at cnt == 3.
   // With start set, the queued stream begins right after the load edge.
   task automatic get_byte(input bit start, output logic [7:0] b,
                           output logic idl, output logic act, output logic rdy3);
      b = '0;
      for (int i = 0; i < 8; i++) begin
         tick();
         b = {b[6:0], data_out};
         if (i == 0) begin
            idl = idle_out;
            act = active;
            if (start && txq.size() > 0) begin
               data_in  = txq.pop_front();
               valid_in = 1'b1;
            end
         end
         if (i == 3) rdy3 = ready_out;
      end
   endtask

   initial begin
      logic [7:0] b;
      logic       idl, act, rdy;

      reset    = 1'b1;
      valid_in = 1'b0;
      data_in  = 8'h00;
      tick();
      tick();
      check("rst_data_out", {7'd0, data_out},  8'h00);
      check("rst_active",   {7'd0, active},    8'h00);
      check("rst_ready",    {7'd0, ready_out}, 8'h00);
      check("rst_idle",     {7'd0, idle_out},  8'h01);
`ifdef SER_TX_BC_COUNT_EN
      check("rst_bc_counter", {4'd0, BC_counter}, 8'h00);
`endif

      // Preamble: four commas with active low; valid_in must be ignored.
      reset    = 1'b0;
      valid_in = 1'b1;
      data_in  = 8'h5A;
      for (int n = 0; n < 4; n++) begin
         get_byte(1'b0, b, idl, act, rdy);
         check($sformatf("pre%0d_byte", n),   b,            8'hBC);
         check($sformatf("pre%0d_active", n), {7'd0, act},  8'h00);
         check($sformatf("pre%0d_idle", n),   {7'd0, idl},  8'h01);
         check($sformatf("pre%0d_ready", n),  {7'd0, rdy},  8'h00);
      end
      check("pre_end_active", {7'd0, active}, 8'h00);
      valid_in = 1'b0;

      // Edge 32 enters ACT; first active byte is idle comma.
      get_byte(1'b0, b, idl, act, rdy);
      check("act0_byte",   b,           8'hBC);
      check("act0_active", {7'd0, act}, 8'h01);
      check("act0_idle",   {7'd0, idl}, 8'h01);
      check("act0_ready_mid", {7'd0, rdy}, 8'h01);
      check("act0_ready_cnt7", {7'd0, ready_out}, 8'h01);

      // Single accept of 0xFF mid-slot: next slot carries it.
      txq = '{8'hFF};
      get_byte(1'b1, b, idl, act, rdy);
      check("single_pre_byte",  b,           8'hBC);
      check("single_ready_full", {7'd0, rdy}, 8'h00);
      get_byte(1'b0, b, idl, act, rdy);
      check("single_byte",      b,           8'hFF);
      check("single_idle",      {7'd0, idl}, 8'h00);
      get_byte(1'b0, b, idl, act, rdy);
      check("single_post_byte", b,           8'hBC);
      check("single_post_idle", {7'd0, idl}, 8'h01);

      // Back-to-back FF, EE, 00 with valid held high.
      txq = '{8'hFF, 8'hEE, 8'h00};
      get_byte(1'b1, b, idl, act, rdy);
      check("b2b_lead_byte", b, 8'hBC);
      get_byte(1'b0, b, idl, act, rdy);
      check("b2b0_byte",  b,           8'hFF);
      check("b2b0_idle",  {7'd0, idl}, 8'h00);
      check("b2b0_ready", {7'd0, rdy}, 8'h00);
      check("b2b0_ready_cnt7", {7'd0, ready_out}, 8'h01);
      get_byte(1'b0, b, idl, act, rdy);
      check("b2b1_byte",  b,           8'hEE);
      check("b2b1_idle",  {7'd0, idl}, 8'h00);
      check("b2b1_ready", {7'd0, rdy}, 8'h00);
      get_byte(1'b0, b, idl, act, rdy);
      check("b2b2_byte",  b,           8'h00);
      check("b2b2_idle",  {7'd0, idl}, 8'h00);
      check("b2b2_ready", {7'd0, rdy}, 8'h01);
      check("b2b_valid_dropped", {7'd0, valid_in}, 8'h00);
      get_byte(1'b0, b, idl, act, rdy);
      check("b2b_tail_byte", b,           8'hBC);
      check("b2b_tail_idle", {7'd0, idl}, 8'h01);

      // 0xA5 accepted on the same edge 0x3C drains.
      txq = '{8'h3C, 8'hA5};
      get_byte(1'b1, b, idl, act, rdy);
      check("swap_lead_byte", b, 8'hBC);
      get_byte(1'b0, b, idl, act, rdy);
      check("swap0_byte", b,           8'h3C);
      check("swap0_idle", {7'd0, idl}, 8'h00);
      get_byte(1'b0, b, idl, act, rdy);
      check("swap1_byte", b,           8'hA5);
      check("swap1_idle", {7'd0, idl}, 8'h00);
      get_byte(1'b0, b, idl, act, rdy);
      check("swap_tail_byte", b,           8'hBC);
      check("swap_tail_idle", {7'd0, idl}, 8'h01);

      // Buffer 0xFF, then a one-cycle reset mid-byte.
      tick();
      data_in  = 8'hFF;
      valid_in = 1'b1;
      tick();
      tick();
      tick();
      reset = 1'b1;
      tick();
      check("mid_rst_data_out", {7'd0, data_out},  8'h00);
      check("mid_rst_active",   {7'd0, active},    8'h00);
      check("mid_rst_ready",    {7'd0, ready_out}, 8'h00);
      check("mid_rst_idle",     {7'd0, idle_out},  8'h01);
      reset = 1'b0;

      // Full preamble again, the discarded 0xFF never appears.
      for (int n = 1; n <= 20; n++) begin
         get_byte(1'b0, b, idl, act, rdy);
         check($sformatf("restart%0d_byte", n),   b,           8'hBC);
         check($sformatf("restart%0d_active", n), {7'd0, act}, (n >= 5) ? 8'h01 : 8'h00);
         check($sformatf("restart%0d_idle", n),   {7'd0, idl}, 8'h01);
         if (n == 6)
            check("restart_buffer_empty", {7'd0, rdy}, 8'h01);
`ifdef SER_TX_BC_COUNT_EN
         check($sformatf("bc_counter%0d", n), {4'd0, BC_counter},
               (n > 15) ? 8'd15 : 8'(n));
`endif
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_serial_paralelo_tx
`default_nettype wire
